gyro_yaw_intf: RTL and testbench
================================

Name: gyro_yaw_intf

Overview:
Upstream command sequencer for the SPI master that talks to the inertial sensor. After reset it waits for sensor power-up, then issues a fixed four-write configuration sequence. After that, on each sensor data-ready interrupt (INT), it reads the yaw-rate low and high bytes and presents a signed 16-bit yaw rate with a one-cycle valid strobe. It is the only block that drives the SPI master's wrt/cmd inputs and consumes its done/rd_data outputs.

Parameters:
PWRUP_W, 16, width of the power-up wait counter; wait lasts 2^PWRUP_W clk cycles after reset.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
INT  input  1  sensor data-ready interrupt; asynchronous to clk; active-high level
done  input  1  SPI master transaction complete; one-clk pulse
rd_data  input  16  SPI master read data; valid in the cycle done is high
wrt  output  1  SPI master start strobe; one-clk pulse
cmd  output  16  SPI command word {R/W, addr[6:0], data[7:0]}
init_done  output  1  high once the configuration sequence completes; sticky until reset
yaw_rt  output  16  signed yaw rate {yawH, yawL}
vld  output  1  one-clk pulse; yaw_rt updated in the same cycle

Behaviour:
- Reset values: wrt=0, cmd=16'h0000, init_done=0, yaw_rt=16'h0000, vld=0, power-up counter=0, FSM=PWRUP.
- INT is double-flopped, and the FSM uses only the second flop (INT_s). This adds 2 clk of latency from INT.
- FSM states and transitions:
  - PWRUP: counter increments each clk; on all-ones -> CFG0.
  - CFG0..CFG3 send cmd 16'h0D02, 16'h1062, 16'h1162, 16'h1460 in order.
  - RDL sends cmd 16'hA600 (yaw low); RDH sends cmd 16'hA700 (yaw high).
  - IDLE: wait for INT_s=1 -> RDL.
- Transaction rule, common to CFGn/RDL/RDH:
  - On entering the state, register cmd and pulse wrt for exactly 1 clk.
  - Hold cmd stable until done.
  - Ignore done in the entry cycle.
  - On done: CFGn -> next CFG; CFG3 -> IDLE and set init_done; RDL -> RDH; RDH -> IDLE.
- Data capture:
  - On done in RDL: yawL <= rd_data[7:0].
  - On done in RDH, registered on the same edge: yaw_rt <= {rd_data[7:0], yawL} and vld <= 1 for one clk.
- Back-to-back reads: INT is level-sensitive. If INT_s is still 1 on the first IDLE cycle after RDH, RDL starts the next cycle; there is no minimum gap.
- Writes never assert vld. yaw_rt holds its last value between reads.
- done pulses arriving in PWRUP or IDLE are ignored; no state change and no capture.
- INT during PWRUP or CFGn is ignored; it is serviced only from IDLE.
- Reset mid-transaction: all state returns to reset values and the power-up wait restarts. The SPI master receives no further wrt until CFG0.
- At most one wrt per transaction; wrt is never asserted while waiting for done.

Test Plan:
1. Reset with PWRUP_W=4 -> 16 clk of wrt=0, then wrt pulses with cmd 0D02, 1062, 1162, 1460. Each pulse occurs only after the prior done. init_done=1 after the 4th done.
2. After init, INT=1 for 3 clk; SPI model returns rd_data 16'h0034 then 16'h0012 -> cmd A600 then A700; yaw_rt=16'h1234 with vld=1 for exactly 1 clk, in the cycle after the second done.
3. Negative rate: return 16'h00F0 then 16'h00FF -> yaw_rt=16'hFFF0, vld 1 clk. Upper rd_data byte set to 8'hAA in both replies -> no effect on yaw_rt.
4. INT held high continuously -> reads repeat back-to-back with vld each pair. Spurious done pulses injected in IDLE -> no state change, no vld.
5. INT pulsed during CFG1 -> ignored, no A600 until after init_done. Reset asserted during RDH -> all outputs return to 0 and the power-up wait restarts.
6. Two INT edges separated by 1 clk while in RDL -> exactly one read pair. yaw_rt is stable between vld pulses.

Source files
------------

// File: rtl/gyro_yaw_intf.sv
// Command sequencer for the inertial-sensor SPI master: power-up wait, four
// configuration writes, then a yaw-rate low/high read pair per data-ready interrupt.
module gyro_yaw_intf #(
    parameter int PWRUP_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        init_done,
    output logic [15:0] yaw_rt,
    output logic        vld
);

    typedef enum logic [2:0] {
        PWRUP, CFG0, CFG1, CFG2, CFG3, IDLE, RDL, RDH
    } state_t;

    state_t               state_q, state_d;
    logic [PWRUP_W-1:0]   cnt_q, cnt_d;
    logic                 int_ff1_q, int_s_q;
    logic                 wrt_q, wrt_d;
    logic [15:0]          cmd_q, cmd_d;
    logic                 init_done_q, init_done_d;
    logic [7:0]           yawl_q, yawl_d;
    logic [15:0]          yaw_rt_q, yaw_rt_d;
    logic                 vld_q, vld_d;
    logic                 done_ok;

    function automatic logic [15:0] state_cmd(input state_t s);
        case (s)
            CFG0:    state_cmd = 16'h0D02;
            CFG1:    state_cmd = 16'h1062;
            CFG2:    state_cmd = 16'h1162;
            CFG3:    state_cmd = 16'h1460;
            RDL:     state_cmd = 16'hA600;
            RDH:     state_cmd = 16'hA700;
            default: state_cmd = 16'h0000;
        endcase
    endfunction

    function automatic logic is_txn(input state_t s);
        is_txn = (s != PWRUP) && (s != IDLE);
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wrt_d       = 1'b0;
        cmd_d       = cmd_q;
        init_done_d = init_done_q;
        yawl_d      = yawl_q;
        yaw_rt_d    = yaw_rt_q;
        vld_d       = 1'b0;
        // wrt_q is high only in the entry cycle, so it masks done there
        done_ok     = done && !wrt_q;

        case (state_q)
            PWRUP: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = CFG0;
            end
            CFG0: if (done_ok) state_d = CFG1;
            CFG1: if (done_ok) state_d = CFG2;
            CFG2: if (done_ok) state_d = CFG3;
            CFG3: begin
                if (done_ok) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: if (int_s_q) state_d = RDL;
            RDL: begin
                if (done_ok) begin
                    yawl_d  = rd_data[7:0];
                    state_d = RDH;
                end
            end
            RDH: begin
                if (done_ok) begin
                    yaw_rt_d = {rd_data[7:0], yawl_q};
                    vld_d    = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = PWRUP;
        endcase

        // Launch exactly one SPI transaction on entry to any command state
        if ((state_d != state_q) && is_txn(state_d)) begin
            wrt_d = 1'b1;
            cmd_d = state_cmd(state_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PWRUP;
            cnt_q       <= '0;
            int_ff1_q   <= 1'b0;
            int_s_q     <= 1'b0;
            wrt_q       <= 1'b0;
            cmd_q       <= 16'h0000;
            init_done_q <= 1'b0;
            yawl_q      <= 8'h00;
            yaw_rt_q    <= 16'h0000;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            int_ff1_q   <= INT;
            int_s_q     <= int_ff1_q;
            wrt_q       <= wrt_d;
            cmd_q       <= cmd_d;
            init_done_q <= init_done_d;
            yawl_q      <= yawl_d;
            yaw_rt_q    <= yaw_rt_d;
            vld_q       <= vld_d;
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign init_done = init_done_q;
    assign yaw_rt    = yaw_rt_q;
    assign vld       = vld_q;

endmodule

// File: tb/tb_gyro_yaw_intf.sv
// Scoreboard bench for gyro_yaw_intf with a small SPI-master responder model.
module tb_gyro_yaw_intf;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic        init_done;
    logic [15:0] yaw_rt;
    logic        vld;

    gyro_yaw_intf #(.PWRUP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .init_done(init_done), .yaw_rt(yaw_rt), .vld(vld)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_cmd[$];
    logic [15:0] exp_yaw[$];
    logic [15:0] rd_q[$];
    int spur = 0;
    logic busy = 1'b0;
    int rdh_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    // SPI master responder: done LAT+1 negedges after wrt, optional spurious done
    initial begin : spi_model
        int lat;
        logic [15:0] reply;
        lat = 0;
        reply = 16'h0000;
        done = 1'b0;
        rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
                lat = 0;
            end else if (busy) begin
                if (wrt) check("wrt_while_busy", wrt, 1'b0);
                if (lat == 0) begin
                    done = 1'b1;
                    rd_data = reply;
                    busy = 1'b0;
                end else begin
                    lat--;
                end
            end else if (wrt) begin
                busy = 1'b1;
                lat = LAT;
                reply = 16'h0000;
                if (cmd[15]) begin
                    if (rd_q.size() == 0) fail_now("no_reply_queued");
                    else reply = rd_q.pop_front();
                end
            end else if (spur > 0) begin
                spur--;
                done = 1'b1;
                rd_data = 16'h0055;
            end
        end
    end

    // Monitor: compare every wrt/cmd and every vld/yaw_rt against the queues
    initial begin : monitor
        logic [15:0] last_yaw;
        logic [15:0] e;
        last_yaw = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_yaw = 16'h0000;
            end else begin
                if (wrt) begin
                    if (exp_cmd.size() == 0) check("unexpected_wrt", cmd, 16'hxxxx);
                    else begin
                        e = exp_cmd.pop_front();
                        check("cmd", cmd, e);
                    end
                    if (cmd[15]) check("read_before_init", init_done, 1'b1);
                    if (cmd == 16'hA700) rdh_cnt++;
                end
                if (vld) begin
                    if (exp_yaw.size() == 0) check("unexpected_vld", yaw_rt, 16'hxxxx);
                    else begin
                        e = exp_yaw.pop_front();
                        check("yaw_rt", yaw_rt, e);
                    end
                end else if (yaw_rt !== last_yaw) begin
                    check("yaw_hold", yaw_rt, last_yaw);
                end
                last_yaw = yaw_rt;
            end
        end
    end

    task automatic push_cfg();
        exp_cmd.push_back(16'h0D02);
        exp_cmd.push_back(16'h1062);
        exp_cmd.push_back(16'h1162);
        exp_cmd.push_back(16'h1460);
    endtask

    task automatic push_read(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] y);
        exp_cmd.push_back(16'hA600);
        exp_cmd.push_back(16'hA700);
        rd_q.push_back(lo);
        rd_q.push_back(hi);
        exp_yaw.push_back(y);
    endtask

    task automatic wait_quiet(input string nm);
        int ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_cmd.size() == 0 && exp_yaw.size() == 0 && !busy && !done) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) fail_now(nm);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wrt"}, wrt, 1'b0);
        check({tag, "_cmd"}, cmd, 16'h0000);
        check({tag, "_init_done"}, init_done, 1'b0);
        check({tag, "_yaw_rt"}, yaw_rt, 16'h0000);
        check({tag, "_vld"}, vld, 1'b0);
    endtask

    task automatic powerup_and_config(input string tag);
        int pw;
        pw = 0;
        push_cfg();
        rst_n = 1'b1;
        spur = 3;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (wrt) begin
                pw = i;
                break;
            end
        end
        check({tag, "_pwrup_len"}, pw, 16);
        check({tag, "_init_early"}, init_done, 1'b0);
    endtask

    task automatic wait_rdh(input int target);
        for (int i = 0; i < 300 && rdh_cnt < target; i++) @(negedge clk);
        if (rdh_cnt < target) fail_now("rdh_timeout");
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        rst_n = 1'b0;
        INT = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Power-up wait, configuration writes, init_done only after the 4th done
        powerup_and_config("t1");
        for (int i = 0; i < 100 && exp_cmd.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("init_before_cfg3_done", init_done, 1'b0);
        wait_quiet("t1_quiet");
        check("init_done", init_done, 1'b1);

        // Positive rate
        push_read(16'h0034, 16'h0012, 16'h1234);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        wait_quiet("t2_quiet");

        // Negative rate, upper reply byte ignored
        push_read(16'hAAF0, 16'hAAFF, 16'hFFF0);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        wait_quiet("t3_quiet");

        // Spurious done in IDLE, then back-to-back reads under continuous INT
        spur = 2;
        repeat (10) @(negedge clk);
        push_read(16'h0001, 16'h0010, 16'h1001);
        push_read(16'h00FE, 16'h0080, 16'h80FE);
        push_read(16'h0000, 16'h007F, 16'h7F00);
        base = rdh_cnt;
        INT = 1'b1;
        wait_rdh(base + 3);
        INT = 1'b0;
        wait_quiet("t4_quiet");

        // Second INT pulse arriving during RDL yields one read pair only
        push_read(16'h00CD, 16'h00AB, 16'hABCD);
        INT = 1'b1;
        @(negedge clk);
        INT = 1'b0;
        @(negedge clk);
        INT = 1'b1;
        @(negedge clk);
        INT = 1'b0;
        wait_quiet("t6_quiet");
        repeat (20) @(negedge clk);
        check("t6_yaw_stable", yaw_rt, 16'hABCD);

        // Reset, INT during CFG1 ignored
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst2");
        push_cfg();
        rst_n = 1'b1;
        for (int i = 0; i < 100 && exp_cmd.size() > 2; i++) @(negedge clk);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        wait_quiet("t5_cfg_quiet");
        check("t5_init_done", init_done, 1'b1);
        repeat (10) @(negedge clk);

        // One full read, then reset while RDH is waiting for done
        push_read(16'h0078, 16'h0056, 16'h5678);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        wait_quiet("t5_read_quiet");
        exp_cmd.push_back(16'hA600);
        exp_cmd.push_back(16'hA700);
        rd_q.push_back(16'h0011);
        rd_q.push_back(16'h0022);
        base = rdh_cnt;
        INT = 1'b1;
        wait_rdh(base + 1);
        INT = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_rdh");
        repeat (2) @(negedge clk);
        powerup_and_config("t5");
        wait_quiet("t5_reinit_quiet");
        check("t5_reinit_done", init_done, 1'b1);
        check("t5_yaw_after_reset", yaw_rt, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
